// File: rtl/dac_pkg.sv
// Shared DAC definitions: data width, full-scale codes, capture FSM states
// and a ceil-log2 helper used to size address and count buses.
package dac_pkg;

  localparam int DAC_WIDTH = 13;
  localparam logic signed [DAC_WIDTH-1:0] DAC_MAX = 13'sh0FFF;  // +4095
  localparam logic signed [DAC_WIDTH-1:0] DAC_MIN = 13'sh1000;  // -4096

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_TAIL,
    ST_DONE
  } cap_state_e;

  // Smallest r with 2**r >= n.
  function automatic int unsigned log2c(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/dac_capture_ram.sv
// Capture buffer: simple dual-port RAM, synchronous write, registered read
// (1-cycle latency). Contents are not reset.
module dac_capture_ram #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = 13,
  parameter int unsigned AW    = 9
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read port, registered output.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dac_capture.sv
// DAC output capture: records every DAC sample edge inside the store strobe
// window (plus a tail to catch the clear sample), then plays the buffer back
// one sample per rd_req. Optional feature: define SAT_COUNT_EN to add the
// sat_count output counting stored full-scale samples.
module dac_capture
  import dac_pkg::*;
#(
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned TAIL_CYCLES = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        arm,
  input  logic                        store_strb,
  input  logic signed [DAC_WIDTH-1:0] dac_dout,
  input  logic                        dac_en,
  input  logic                        rd_req,
  output logic signed [DAC_WIDTH-1:0] rd_data,
  output logic                        rd_valid,
  output logic                        rd_last,
  output logic [log2c(DEPTH):0]       sample_count,
  output logic                        done,
  output logic                        overflow
`ifdef SAT_COUNT_EN
  ,
  output logic [log2c(DEPTH):0]       sat_count
`endif
);

  localparam int unsigned AW = log2c(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [31:0]   TAIL_LOAD = 32'(TAIL_CYCLES - 1);

  cap_state_e        state_q, state_d;
  logic              dac_en_q, strb_q;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       tail_q, tail_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
`ifdef SAT_COUNT_EN
  logic [CW-1:0]     sat_q, sat_d;
`endif

  logic              dac_edge, strb_rise, strb_fall;
  logic              ram_we, ram_re;
  logic [DAC_WIDTH-1:0] ram_rdata;

  assign dac_edge  = dac_en & ~dac_en_q;
  assign strb_rise = store_strb & ~strb_q;
  assign strb_fall = ~store_strb & strb_q;

  // State and datapath registers; rst wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dac_en_q   <= 1'b0;
      strb_q     <= 1'b0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
      tail_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
`ifdef SAT_COUNT_EN
      sat_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      dac_en_q   <= dac_en;
      strb_q     <= store_strb;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
      tail_q     <= tail_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
`ifdef SAT_COUNT_EN
      sat_q      <= sat_d;
`endif
    end
  end

  // Next-state, capture writes and playback reads; arm overrides all events.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    ovf_d      = ovf_q;
    tail_d     = tail_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
`ifdef SAT_COUNT_EN
    sat_d      = sat_q;
`endif
    if (arm) begin
      state_d  = ST_ARMED;
      wr_ptr_d = '0;
      count_d  = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
`ifdef SAT_COUNT_EN
      sat_d    = '0;
`endif
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (strb_rise) state_d = ST_CAPTURE;
        end
        ST_CAPTURE, ST_TAIL: begin
          if (dac_edge) begin
            if (count_q == FULL) begin
              ovf_d = 1'b1;
            end else begin
              ram_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + 1'b1;
              count_d  = count_q + 1'b1;
`ifdef SAT_COUNT_EN
              if (dac_dout == DAC_MAX || dac_dout == DAC_MIN) sat_d = sat_q + 1'b1;
`endif
            end
          end
          if (state_q == ST_CAPTURE) begin
            if (strb_fall) begin
              state_d = ST_TAIL;
              tail_d  = TAIL_LOAD;
            end
          end else if (tail_q == '0) begin
            state_d = ST_DONE;
          end else begin
            tail_d = tail_q - 1'b1;
          end
        end
        ST_DONE: begin
          if (rd_req && rd_ptr_q != count_q) begin
            ram_re     = 1'b1;
            rd_ptr_d   = rd_ptr_q + 1'b1;
            rd_valid_d = 1'b1;
            rd_last_d  = (rd_ptr_q == count_q - 1'b1);
          end
        end
        default: ;
      endcase
    end
  end

  dac_capture_ram #(
    .DEPTH (DEPTH),
    .WIDTH (DAC_WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (dac_dout),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  // The RAM read register is not reset, so rd_data is forced to 0 whenever
  // it is not qualified; this also gives rd_data=0 straight out of rst.
  assign rd_data      = rd_valid_q ? ram_rdata : '0;
  assign rd_valid     = rd_valid_q;
  assign rd_last      = rd_last_q;
  assign sample_count = count_q;
  assign done         = (state_q == ST_DONE);
  assign overflow     = ovf_q;
`ifdef SAT_COUNT_EN
  assign sat_count    = sat_q;
`endif

endmodule

// File: tb/tb_dac_capture.sv
// Scoreboard bench for dac_capture: per-cycle stimulus plans, a window-based
// reference model, and a read monitor that pops expected samples.
module tb_dac_capture;
  import dac_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TAIL  = 8;
  localparam int unsigned CW    = 5;
  localparam int          L     = 64;

  logic clk = 1'b0;
  logic rst = 1'b1, arm = 1'b0, store_strb = 1'b0, dac_en = 1'b0, rd_req = 1'b0;
  logic signed [12:0] dac_dout = '0;
  logic signed [12:0] rd_data;
  logic rd_valid, rd_last, done, overflow;
  logic [CW-1:0] sample_count;
`ifdef SAT_COUNT_EN
  logic [CW-1:0] sat_count;
`endif

  always #5 clk = ~clk;

  dac_capture #(
    .DEPTH       (DEPTH),
    .TAIL_CYCLES (TAIL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .store_strb   (store_strb),
    .dac_dout     (dac_dout),
    .dac_en       (dac_en),
    .rd_req       (rd_req),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_last      (rd_last),
    .sample_count (sample_count),
    .done         (done),
    .overflow     (overflow)
`ifdef SAT_COUNT_EN
    ,
    .sat_count    (sat_count)
`endif
  );

  typedef struct {
    logic signed [12:0] data;
    logic               last;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  rd_exp_t mon_e;
  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus plan for one capture and the model's view of it.
  logic               p_s0;
  logic               p_strb [L];
  logic               p_en   [L];
  logic signed [12:0] p_dout [L];
  int                 m_rise, m_fall, m_total;
  logic signed [12:0] m_stored[$];

  logic req_at_edge = 1'b0;
  always @(posedge clk) req_at_edge <= rd_req;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every rd_valid must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_valid === 1'b1) begin
        n_cmp++;
        if (req_at_edge !== 1'b1) begin
          n_bad++;
          $display("FAIL rd_latency: rd_valid=1 but rd_req was 0 one cycle earlier");
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rd_unexpected: got rd_valid with data %0d, expected no read", rd_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (rd_data !== mon_e.data) begin
            n_bad++;
            $display("FAIL rd_data: got %0d expected %0d", rd_data, mon_e.data);
          end
          n_cmp++;
          if (rd_last !== mon_e.last) begin
            n_bad++;
            $display("FAIL rd_last: got %0b expected %0b", rd_last, mon_e.last);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_plan(input logic s0);
    p_s0 = s0;
    for (int i = 0; i < L; i++) begin
      p_strb[i] = 1'b0;
      p_en[i]   = 1'b0;
      p_dout[i] = '0;
    end
  endtask

  // Window model: capture runs from the cycle after the first strobe rise
  // through TAIL cycles after the following fall; the first DEPTH edges stick.
  task automatic run_model();
    logic prev_s, prev_e;
    m_rise = -1;
    m_fall = -1;
    m_total = 0;
    m_stored.delete();
    for (int i = 0; i < L; i++) begin
      prev_s = (i == 0) ? p_s0 : p_strb[i-1];
      if (m_rise < 0 && p_strb[i] && !prev_s) m_rise = i;
      else if (m_rise >= 0 && m_fall < 0 && !p_strb[i]) m_fall = i;
    end
    if (m_rise < 0) return;
    for (int i = m_rise + 1; i <= m_fall + int'(TAIL) && i < L; i++) begin
      prev_e = p_en[i-1];
      if (p_en[i] && !prev_e) begin
        m_total++;
        if (m_stored.size() < DEPTH) m_stored.push_back(p_dout[i]);
      end
    end
  endtask

  function automatic int model_sat();
    int n = 0;
    foreach (m_stored[k]) if (m_stored[k] == DAC_MAX || m_stored[k] == DAC_MIN) n++;
    return n;
  endfunction

  task automatic run_plan(input string name, input bit do_arm);
    if (do_arm) begin
      arm = 1'b1; store_strb = p_s0; dac_en = 1'b0; dac_dout = '0; rd_req = 1'b0;
      step();
      arm = 1'b0;
    end
    run_model();
    for (int i = 0; i < L; i++) begin
      store_strb = p_strb[i];
      dac_en     = p_en[i];
      dac_dout   = p_dout[i];
      step();
      if (m_rise >= 0 && i == m_fall + int'(TAIL) - 1) check({name, "_done_early"}, done, 0);
      if (m_rise >= 0 && i == m_fall + int'(TAIL))     check({name, "_done_on_time"}, done, 1);
    end
    store_strb = 1'b0;
    dac_en = 1'b0;
    check({name, "_done"}, done, (m_rise >= 0) ? 1 : 0);
    check({name, "_count"}, sample_count, m_stored.size());
    check({name, "_overflow"}, overflow, (m_total > int'(DEPTH)) ? 1 : 0);
`ifdef SAT_COUNT_EN
    check({name, "_sat_count"}, sat_count, model_sat());
`endif
  endtask

  task automatic do_reads(input string name, input int extra);
    int n;
    for (int k = 0; k < m_stored.size(); k++)
      exp_q.push_back('{data: m_stored[k], last: (k == m_stored.size() - 1)});
    n = m_stored.size() + extra;
    for (int k = 0; k < n; k++) begin
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
    repeat (3) step();
    check({name, "_queue_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    // Reset values.
    repeat (3) step();
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_count", sample_count, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
`ifdef SAT_COUNT_EN
    check("rst_sat_count", sat_count, 0);
`endif
    rst = 1'b0;
    step();

    // rd_req in IDLE is ignored.
    do_reads("idle", 2);

    // Basic capture: 10 edges 1..10 during a 20-cycle strobe plus clear edge 0.
    clear_plan(1'b0);
    for (int i = 1; i <= 20; i++) p_strb[i] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      p_en[2 + 2*k] = 1'b1;
      p_dout[2 + 2*k] = 13'(k + 1);
    end
    p_en[22] = 1'b1;
    p_dout[22] = 0;
    run_plan("basic", 1'b1);
    check("basic_count_11", sample_count, 11);
    do_reads("basic", 2);

    // Overflow: 20 edges into a 16-deep buffer.
    clear_plan(1'b0);
    for (int i = 1; i <= 45; i++) p_strb[i] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      p_en[2 + 2*k] = 1'b1;
      p_dout[2 + 2*k] = 13'(101 + k);
    end
    run_plan("ovf", 1'b1);
    check("ovf_count_16", sample_count, 16);
    check("ovf_flag", overflow, 1);
    do_reads("ovf", 1);

    // Strobe already high at arm: capture only after it drops and rises again.
    clear_plan(1'b1);
    for (int i = 0; i <= 9; i++) p_strb[i] = 1'b1;
    p_en[1] = 1'b1; p_dout[1] = 13'd77;
    p_en[3] = 1'b1; p_dout[3] = 13'd78;
    p_en[11] = 1'b1; p_dout[11] = 13'd99;
    for (int i = 13; i <= 25; i++) p_strb[i] = 1'b1;
    p_en[14] = 1'b1; p_dout[14] = 13'd31;
    p_en[16] = 1'b1; p_dout[16] = 13'd32;
    p_en[18] = 1'b1; p_dout[18] = 13'd33;
    run_plan("strb_high", 1'b1);
    check("strb_high_count_3", sample_count, 3);
    do_reads("strb_high", 1);

    // Strobe high at arm and never re-rising: stays armed, reads ignored.
    clear_plan(1'b1);
    for (int i = 0; i <= 30; i++) begin
      p_strb[i] = 1'b1;
      p_en[i] = i[0];
      p_dout[i] = 13'(i);
    end
    run_plan("no_rise", 1'b1);
    check("no_rise_done", done, 0);
    do_reads("no_rise", 2);

    // Priority: arm + rd_req together in DONE.
    clear_plan(1'b0);
    for (int i = 1; i <= 10; i++) p_strb[i] = 1'b1;
    p_en[3] = 1'b1; p_dout[3] = -13'sd5;
    p_en[5] = 1'b1; p_dout[5] = 13'd6;
    run_plan("prio_a", 1'b1);
    arm = 1'b1; rd_req = 1'b1;
    step();
    arm = 1'b0; rd_req = 1'b0;
    check("prio_rd_valid", rd_valid, 0);
    check("prio_done", done, 0);
    check("prio_count", sample_count, 0);
    step();
    check("prio_rd_valid_next", rd_valid, 0);
    // Now armed: a fresh strobe rise captures without another arm.
    clear_plan(1'b0);
    for (int i = 2; i <= 8; i++) p_strb[i] = 1'b1;
    p_en[4] = 1'b1; p_dout[4] = 13'd7;
    p_en[6] = 1'b1; p_dout[6] = 13'd8;
    run_plan("prio_b", 1'b0);
    do_reads("prio_b", 1);

    // Saturation values.
    clear_plan(1'b0);
    for (int i = 1; i <= 10; i++) p_strb[i] = 1'b1;
    p_en[2] = 1'b1; p_dout[2] = DAC_MAX;
    p_en[4] = 1'b1; p_dout[4] = DAC_MIN;
    p_en[6] = 1'b1; p_dout[6] = 13'd100;
    run_plan("sat", 1'b1);
`ifdef SAT_COUNT_EN
    check("sat_count_2", sat_count, 2);
`endif
    do_reads("sat", 0);

    // Empty capture.
    clear_plan(1'b0);
    for (int i = 1; i <= 10; i++) p_strb[i] = 1'b1;
    run_plan("empty", 1'b1);
    check("empty_done", done, 1);
    check("empty_count", sample_count, 0);
    do_reads("empty", 3);

    // Randomized captures.
    for (int r = 0; r < 10; r++) begin
      logic s;
      s = 1'($urandom_range(0, 1));
      clear_plan(s);
      for (int i = 0; i < L; i++) begin
        if (i < 48 && $urandom_range(0, 5) == 0) s = ~s;
        p_strb[i] = (i < 48) ? s : 1'b0;
        p_en[i] = 1'($urandom);
        case ($urandom_range(0, 7))
          0: p_dout[i] = DAC_MAX;
          1: p_dout[i] = DAC_MIN;
          default: p_dout[i] = 13'($urandom);
        endcase
      end
      run_plan("rand", 1'b1);
      do_reads("rand", int'($urandom_range(0, 2)));
    end

    // Reset mid-capture with overflow already set.
    clear_plan(1'b0);
    for (int i = 1; i < L; i++) p_strb[i] = 1'b1;
    arm = 1'b1; store_strb = 1'b0; step(); arm = 1'b0;
    store_strb = 1'b1; step();
    for (int k = 0; k < 20; k++) begin
      dac_en = 1'b1; dac_dout = 13'(k + 200); step();
      dac_en = 1'b0; step();
    end
    check("pre_rst_count", sample_count, 16);
    check("pre_rst_overflow", overflow, 1);
    rst = 1'b1;
    step();
    check("midrst_rd_data", rd_data, 0);
    check("midrst_rd_valid", rd_valid, 0);
    check("midrst_rd_last", rd_last, 0);
    check("midrst_count", sample_count, 0);
    check("midrst_done", done, 0);
    check("midrst_overflow", overflow, 0);
`ifdef SAT_COUNT_EN
    check("midrst_sat_count", sat_count, 0);
`endif
    rst = 1'b0;
    store_strb = 1'b0;
    repeat (12) step();
    check("post_rst_done", done, 0);
    m_stored.delete();
    do_reads("post_rst", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
